// File: rtl/mouse_ctrl_pkg.sv
// Shared definitions for the mouse sprite controller: FSM states, register
// offsets in the bus register window and ctrl register bit positions.
package mouse_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Register offsets selected by addr[1:0] when the register region is hit
    localparam logic [1:0] REG_X0   = 2'd0;
    localparam logic [1:0] REG_Y0   = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // addr bit choosing between sprite RAM (0) and registers (1)
    localparam int REGION_BIT = 13;

    // ctrl register bit positions
    localparam int CTRL_START     = 0;
    localparam int CTRL_CLR_OVF   = 1;
    localparam int CTRL_COLOR_LSB = 16;

endpackage

// File: rtl/mouse_sprite_ctrl.sv
// Sprite RAM write-port owner: arbitrates CPU pixel writes against the
// whole-bitmap fill engine and holds the tear-free sprite origin registers.
module mouse_sprite_ctrl
    import mouse_ctrl_pkg::*;
#(
    parameter int             CD        = 12,
    parameter int             ADDR      = 8,
    parameter logic [CD-1:0]  KEY_COLOR = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cs,
    input  logic              i_write,
    input  logic [13:0]       i_addr,
    input  logic [31:0]       i_wr_data,
    output logic [31:0]       o_rd_data,
    input  logic              i_frame_start,
    output logic              o_sprite_we,
    output logic [ADDR-1:0]   o_sprite_addr,
    output logic [CD-1:0]     o_sprite_pixel,
    output logic [10:0]       o_x0,
    output logic [10:0]       o_y0
);

    state_t            r_state;
    logic              r_we;
    logic [ADDR-1:0]   r_addr;
    logic [CD-1:0]     r_pixel;
    logic [ADDR-1:0]   r_fill_cnt;
    logic [CD-1:0]     r_fill_color;
    logic              r_pending;
    logic              r_overflow;
    logic [ADDR-1:0]   r_buf_addr;
    logic [CD-1:0]     r_buf_pixel;
    logic [10:0]       r_x0_sh;
    logic [10:0]       r_y0_sh;
    logic [10:0]       r_x0;
    logic [10:0]       r_y0;

    state_t            w_state_nxt;
    logic              w_we_nxt;
    logic [ADDR-1:0]   w_addr_nxt;
    logic [CD-1:0]     w_pixel_nxt;
    logic [ADDR-1:0]   w_cnt_nxt;
    logic [CD-1:0]     w_color_nxt;
    logic              w_capture;
    logic              w_accept;
    logic              w_pending_nxt;
    logic              w_overflow_nxt;
    logic [ADDR-1:0]   w_buf_addr_nxt;
    logic [CD-1:0]     w_buf_pixel_nxt;

    logic              w_cpu_pix;
    logic              w_reg_wr;
    logic              w_x0_wr;
    logic              w_y0_wr;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_clr_ovf;
    logic              w_fill_last;
    logic              w_busy;
    logic              w_unused;

    assign w_cpu_pix   = i_cs & i_write & ~i_addr[REGION_BIT];
    assign w_reg_wr    = i_cs & i_write &  i_addr[REGION_BIT];
    assign w_x0_wr     = w_reg_wr & (i_addr[1:0] == REG_X0);
    assign w_y0_wr     = w_reg_wr & (i_addr[1:0] == REG_Y0);
    assign w_ctrl_wr   = w_reg_wr & (i_addr[1:0] == REG_CTRL);
    assign w_start     = w_ctrl_wr & i_wr_data[CTRL_START];
    assign w_clr_ovf   = w_ctrl_wr & i_wr_data[CTRL_CLR_OVF];
    assign w_fill_last = (r_fill_cnt == '1);
    assign w_busy      = (r_state != IDLE);
    assign w_unused    = ^{i_addr, i_wr_data};

    assign o_rd_data      = {29'b0, r_overflow, r_pending, w_busy};
    assign o_sprite_we    = r_we;
    assign o_sprite_addr  = r_addr;
    assign o_sprite_pixel = r_pixel;
    assign o_x0           = r_x0;
    assign o_y0           = r_y0;

    // Next state and next write-port values; a ctrl start issues address 0
    // immediately so the first fill write appears one cycle after the start
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_pixel_nxt = r_pixel;
        w_cnt_nxt   = r_fill_cnt;
        w_color_nxt = r_fill_color;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cpu_pix) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = i_addr[ADDR-1:0];
                    w_pixel_nxt = i_wr_data[CD-1:0];
                end else if (w_start) begin
                    w_color_nxt = i_wr_data[CTRL_COLOR_LSB +: CD];
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                    w_pixel_nxt = i_wr_data[CTRL_COLOR_LSB +: CD];
                    w_cnt_nxt   = ADDR'(1);
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                w_we_nxt    = 1'b1;
                w_addr_nxt  = r_fill_cnt;
                w_pixel_nxt = r_fill_color;
                w_capture   = w_cpu_pix;
                if (w_fill_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_pending | w_cpu_pix) ? DRAIN : IDLE;
                end else begin
                    w_cnt_nxt = r_fill_cnt + ADDR'(1);
                end
            end
            DRAIN: begin
                w_we_nxt    = 1'b1;
                w_addr_nxt  = r_buf_addr;
                w_pixel_nxt = r_buf_pixel;
                w_capture   = w_cpu_pix;
                w_state_nxt = w_cpu_pix ? DRAIN : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // One-entry write buffer: in DRAIN the old entry is leaving this cycle,
    // so a new CPU write can take the slot instead of being dropped
    always_comb begin
        w_accept        = w_capture & (~r_pending | (r_state == DRAIN));
        w_pending_nxt   = r_pending;
        w_overflow_nxt  = r_overflow;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_pixel_nxt = r_buf_pixel;
        if (r_state == DRAIN) begin
            w_pending_nxt = 1'b0;
        end
        if (w_accept) begin
            w_pending_nxt   = 1'b1;
            w_buf_addr_nxt  = i_addr[ADDR-1:0];
            w_buf_pixel_nxt = i_wr_data[CD-1:0];
        end
        if (w_clr_ovf) begin
            w_overflow_nxt = 1'b0;
        end
        if (w_capture & ~w_accept) begin
            w_overflow_nxt = 1'b1;
        end
    end

    // FSM, fill engine, buffer and registered write-port outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= FILL;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_pixel      <= '0;
            r_fill_cnt   <= '0;
            r_fill_color <= KEY_COLOR;
            r_pending    <= 1'b0;
            r_overflow   <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_pixel  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_pixel      <= w_pixel_nxt;
            r_fill_cnt   <= w_cnt_nxt;
            r_fill_color <= w_color_nxt;
            r_pending    <= w_pending_nxt;
            r_overflow   <= w_overflow_nxt;
            r_buf_addr   <= w_buf_addr_nxt;
            r_buf_pixel  <= w_buf_pixel_nxt;
        end
    end

    // Origin shadows commit on frame start; a same-cycle write goes straight through
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x0_sh <= '0;
            r_y0_sh <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
        end else begin
            if (w_x0_wr) begin
                r_x0_sh <= i_wr_data[10:0];
            end
            if (w_y0_wr) begin
                r_y0_sh <= i_wr_data[10:0];
            end
            if (i_frame_start) begin
                r_x0 <= w_x0_wr ? i_wr_data[10:0] : r_x0_sh;
                r_y0 <= w_y0_wr ? i_wr_data[10:0] : r_y0_sh;
            end
        end
    end

endmodule

// File: tb/tb_mouse_sprite_ctrl.sv
// Self-checking bench for mouse_sprite_ctrl: directed vector table, hand
// sequences for fill/drain/overflow/reset, and randomized traffic against a
// count-based behavioural model.
module tb_mouse_sprite_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        frameStart;
    logic        spriteWe;
    logic [7:0]  spriteAddr;
    logic [11:0] spritePixel;
    logic [10:0] x0;
    logic [10:0] y0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [13:0] a;
        logic [31:0] d;
        logic        fs;
        logic        expWe;
        logic [7:0]  expAddr;
        logic [11:0] expPix;
        logic [10:0] expX0;
        logic [10:0] expY0;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[$];

    mouse_sprite_ctrl #(.CD(12), .ADDR(8), .KEY_COLOR(12'h000)) dut (
        .i_clk          (clk),
        .i_reset_n      (rstN),
        .i_cs           (cs),
        .i_write        (write),
        .i_addr         (addr),
        .i_wr_data      (wrData),
        .o_rd_data      (rdData),
        .i_frame_start  (frameStart),
        .o_sprite_we    (spriteWe),
        .o_sprite_addr  (spriteAddr),
        .o_sprite_pixel (spritePixel),
        .o_x0           (x0),
        .o_y0           (y0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [13:0] a,
                                 input logic [31:0] d, input logic fs);
        cs         = c;
        write      = w;
        addr       = a;
        wrData     = d;
        frameStart = fs;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string name, input logic [7:0] a, input logic [11:0] p);
        checkOutput(name, {11'b0, spriteWe, spriteAddr, spritePixel}, {11'b0, 1'b1, a, p});
    endtask

    // Hold reset a few cycles, check the reset state, release just after an edge
    task automatic doReset();
        rstN = 1'b0;
        idle();
        repeat (3) tick();
        checkOutput("reset we", {31'b0, spriteWe}, 32'h0);
        checkOutput("reset addr", {24'b0, spriteAddr}, 32'h0);
        checkOutput("reset pixel", {20'b0, spritePixel}, 32'h0);
        checkOutput("reset x0y0", {10'b0, x0, y0}, 32'h0);
        checkOutput("reset status", rdData, 32'h1);
        rstN = 1'b1;
    endtask

    // Expect a complete key-colour fill 0..255 followed by an idle port
    task automatic checkKeyFill(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checkWrite(name, 8'(i), 12'h000);
        end
        tick();
        checkOutput({name, " we after"}, {31'b0, spriteWe}, 32'h0);
        checkOutput({name, " busy after"}, rdData, 32'h0);
    endtask

    // Behavioural model state for randomized traffic
    int          mFillLeft;
    logic        mDrain;
    logic        mBufValid;
    logic [7:0]  mBufA;
    logic [11:0] mBufP;
    logic        mOvf;
    logic [11:0] mColor;
    logic [10:0] mShX, mShY, mX, mY;

    initial begin
        logic        isPix, isReg, expWe;
        logic [7:0]  expA;
        logic [11:0] expP;
        logic [31:0] expRd;
        logic [12:0] rA;
        int          r;

        // Post-reset key-colour fill
        doReset();
        checkKeyFill("post-reset fill");

        // Directed vectors from idle
        vecs.push_back('{1'b1, 1'b1, 14'h0012, 32'h0000_0F0F, 1'b0, 1'b1, 8'h12, 12'hF0F, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b0, 1'b0, 14'h0000, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 12'h000, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b1, 1'b0, 14'h0034, 32'h0000_0555, 1'b0, 1'b0, 8'h00, 12'h000, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2000, 32'd100,       1'b0, 1'b0, 8'h00, 12'h000, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2001, 32'd50,        1'b0, 1'b0, 8'h00, 12'h000, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b0, 1'b0, 14'h0000, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 12'h000, 11'd0,   11'd0,   32'h0});
        vecs.push_back('{1'b0, 1'b0, 14'h0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 12'h000, 11'd100, 11'd50,  32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2000, 32'd200,       1'b1, 1'b0, 8'h00, 12'h000, 11'd200, 11'd50,  32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h1FFF, 32'hFFFF_F0A5, 1'b0, 1'b1, 8'hFF, 12'h0A5, 11'd200, 11'd50,  32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2003, 32'h0000_0123, 1'b0, 1'b0, 8'h00, 12'h000, 11'd200, 11'd50,  32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2001, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 12'h000, 11'd200, 11'd50,  32'h0});
        vecs.push_back('{1'b0, 1'b0, 14'h0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 12'h000, 11'd200, 11'h7FF, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 14'h2002, 32'h0000_0002, 1'b0, 1'b0, 8'h00, 12'h000, 11'd200, 11'h7FF, 32'h0});
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].cs, vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].fs);
            tick();
            checkOutput($sformatf("vec%0d we", v), {31'b0, spriteWe}, {31'b0, vecs[v].expWe});
            if (vecs[v].expWe) begin
                checkOutput($sformatf("vec%0d addr", v), {24'b0, spriteAddr}, {24'b0, vecs[v].expAddr});
                checkOutput($sformatf("vec%0d pixel", v), {20'b0, spritePixel}, {20'b0, vecs[v].expPix});
            end
            checkOutput($sformatf("vec%0d x0", v), {21'b0, x0}, {21'b0, vecs[v].expX0});
            checkOutput($sformatf("vec%0d y0", v), {21'b0, y0}, {21'b0, vecs[v].expY0});
            checkOutput($sformatf("vec%0d status", v), rdData, vecs[v].expRd);
        end

        // Recolour fill with one buffered CPU write and an ignored restart
        applyStimulus(1'b1, 1'b1, 14'h2002, 32'h0ABC_0001, 1'b0);
        tick();
        checkWrite("abc fill", 8'h00, 12'hABC);
        checkOutput("abc busy", rdData, 32'h1);
        for (int i = 1; i < DEPTH; i++) begin
            if (i == 10)      applyStimulus(1'b1, 1'b1, 14'h0005, 32'h0000_0123, 1'b0);
            else if (i == 40) applyStimulus(1'b1, 1'b1, 14'h2002, 32'h0555_0001, 1'b0);
            else              idle();
            tick();
            checkWrite("abc fill", 8'(i), 12'hABC);
            if (i == 10)  checkOutput("abc pending", rdData, 32'h3);
            if (i == 255) checkOutput("abc into drain", rdData, 32'h3);
        end
        idle();
        tick();
        checkWrite("abc drain", 8'h05, 12'h123);
        checkOutput("abc after drain", rdData, 32'h0);
        tick();
        checkOutput("abc we idle", {31'b0, spriteWe}, 32'h0);

        // Two mid-fill writes: second dropped, overflow sticky until cleared
        applyStimulus(1'b1, 1'b1, 14'h2002, 32'h0000_0001, 1'b0);
        tick();
        checkWrite("ovf fill", 8'h00, 12'h000);
        for (int i = 1; i < DEPTH; i++) begin
            if (i == 20)      applyStimulus(1'b1, 1'b1, 14'h0020, 32'h0000_0111, 1'b0);
            else if (i == 30) applyStimulus(1'b1, 1'b1, 14'h0030, 32'h0000_0222, 1'b0);
            else              idle();
            tick();
            checkWrite("ovf fill", 8'(i), 12'h000);
            if (i == 30) checkOutput("ovf set", rdData, 32'h7);
        end
        idle();
        tick();
        checkWrite("ovf drain", 8'h20, 12'h111);
        checkOutput("ovf sticky", rdData, 32'h4);
        applyStimulus(1'b1, 1'b1, 14'h2002, 32'h0000_0002, 1'b0);
        tick();
        checkOutput("ovf cleared", rdData, 32'h0);
        checkOutput("ovf clear no write", {31'b0, spriteWe}, 32'h0);

        // Reset mid-fill with a pending write: everything clears, fresh fill follows
        applyStimulus(1'b1, 1'b1, 14'h2002, 32'h0777_0001, 1'b0);
        tick();
        for (int i = 1; i <= 77; i++) begin
            if (i == 10) applyStimulus(1'b1, 1'b1, 14'h0009, 32'h0000_0999, 1'b0);
            else         idle();
            tick();
        end
        checkWrite("pre-reset fill", 8'd77, 12'h777);
        checkOutput("pre-reset pending", rdData, 32'h3);
        idle();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset we", {31'b0, spriteWe}, 32'h0);
        checkOutput("async reset addr/pixel", {12'b0, spriteAddr, spritePixel}, 32'h0);
        checkOutput("async reset status", rdData, 32'h1);
        checkOutput("async reset origin", {10'b0, x0, y0}, 32'h0);
        doReset();
        checkKeyFill("refill after reset");

        // Randomized traffic against the behavioural model (starts idle, all clear)
        mFillLeft = 0;
        mDrain    = 1'b0;
        mBufValid = 1'b0;
        mBufA     = '0;
        mBufP     = '0;
        mOvf      = 1'b0;
        mColor    = '0;
        mShX      = '0;
        mShY      = '0;
        mX        = '0;
        mY        = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = int'($urandom_range(0, 99));
            rA = 13'($urandom);
            idle();
            if (r < 35 && !mDrain) applyStimulus(1'b1, 1'b1, {1'b0, rA}, $urandom, 1'b0);
            else if (r >= 35 && r < 45) applyStimulus(1'b1, 1'b1, {1'b1, rA[12:2], 2'd0}, $urandom, 1'b0);
            else if (r >= 45 && r < 55) applyStimulus(1'b1, 1'b1, {1'b1, rA[12:2], 2'd1}, $urandom, 1'b0);
            else if (r >= 55 && r < 57) applyStimulus(1'b1, 1'b1, {1'b1, rA[12:2], 2'd2}, {$urandom} | 32'h1, 1'b0);
            else if (r >= 57 && r < 60) applyStimulus(1'b1, 1'b1, {1'b1, rA[12:2], 2'd2}, 32'h2, 1'b0);
            else if (r >= 60 && r < 65) applyStimulus(1'b1, 1'b0, {1'b0, rA}, $urandom, 1'b0);
            frameStart = ($urandom_range(0, 15) == 0);

            isPix = cs && write && !addr[13];
            isReg = cs && write && addr[13];
            expWe = 1'b0;
            expA  = '0;
            expP  = '0;
            if (mFillLeft > 0) begin
                expWe = 1'b1;
                expA  = 8'(DEPTH - mFillLeft);
                expP  = mColor;
                mFillLeft--;
                if (isPix) begin
                    if (mBufValid) mOvf = 1'b1;
                    else begin
                        mBufValid = 1'b1;
                        mBufA     = addr[7:0];
                        mBufP     = wrData[11:0];
                    end
                end
                if (mFillLeft == 0 && mBufValid) mDrain = 1'b1;
            end else if (mDrain) begin
                expWe     = 1'b1;
                expA      = mBufA;
                expP      = mBufP;
                mBufValid = 1'b0;
                mDrain    = 1'b0;
            end else if (isPix) begin
                expWe = 1'b1;
                expA  = addr[7:0];
                expP  = wrData[11:0];
            end else if (isReg && addr[1:0] == 2'd2 && wrData[0]) begin
                mColor    = wrData[27:16];
                expWe     = 1'b1;
                expA      = 8'h00;
                expP      = mColor;
                mFillLeft = DEPTH - 1;
            end
            if (isReg && addr[1:0] == 2'd2 && wrData[1]) mOvf = 1'b0;
            if (isReg && addr[1:0] == 2'd0) mShX = wrData[10:0];
            if (isReg && addr[1:0] == 2'd1) mShY = wrData[10:0];
            if (frameStart) begin
                mX = mShX;
                mY = mShY;
            end
            expRd = {29'b0, mOvf, mBufValid, (mFillLeft > 0) || mDrain};

            tick();
            checkOutput("rand we", {31'b0, spriteWe}, {31'b0, expWe});
            if (expWe) checkOutput("rand addr/pixel", {12'b0, spriteAddr, spritePixel}, {12'b0, expA, expP});
            checkOutput("rand origin", {10'b0, x0, y0}, {10'b0, mX, mY});
            checkOutput("rand status", rdData, expRd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_sprite_ctrl.md
# mouse_sprite_ctrl

Bus-side controller for the 16x16 mouse sprite source. It owns the sprite RAM write port and shares it between CPU pixel writes from the bus slot and an internal fill engine, which clears or recolours the whole bitmap. It also holds the sprite origin registers and commits new origins only at frame start, so the cursor never tears mid-frame. It sits between the bus slot (cs/write/addr/wr_data/rd_data) and the sprite source's `we`/`addr_w`/`pixel_in`/`x0`/`y0` inputs.

## Interface
- CD, 12, colour depth of one sprite pixel
- ADDR, 8, sprite RAM address bits (2^ADDR pixels)
- KEY_COLOR, 0, chroma-key colour used by the automatic post-reset fill
- clk  in  1  system clock
- reset_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- cs  in  1  slot select
- write  in  1  write strobe, valid with cs
- addr  in  14  addr[13]=0: sprite RAM pixel at addr[ADDR-1:0]; addr[13]=1: register addr[1:0] (0 = x0, 1 = y0, 2 = ctrl)
- wr_data  in  32  write data
- rd_data  out  32  status: {29'b0, overflow, pending, busy}; returned for any read address
- frame_start  in  1  one-cycle pulse at start of vertical blank
- sprite_we  out  1  sprite RAM write enable
- sprite_addr  out  ADDR  sprite RAM write address
- sprite_pixel  out  CD  sprite RAM write data
- x0  out  11  committed sprite origin x
- y0  out  11  committed sprite origin y

## Operation
- FSM states: IDLE, FILL, DRAIN. Reset state: FILL, with fill colour KEY_COLOR, so the sprite is invisible after reset.
- IDLE
  - A CPU pixel write (cs & write & !addr[13]) drives sprite_we=1, sprite_addr=addr[ADDR-1:0], sprite_pixel=wr_data[CD-1:0] on the next cycle.
  - A ctrl write with wr_data[0]=1 latches fill colour wr_data[CD+15:16] and goes to FILL.
- FILL
  - A counter walks 0 to 2^ADDR-1, one write per cycle with the fill colour.
  - After the last address: go to DRAIN if pending=1, otherwise IDLE.
- DRAIN: issues the buffered CPU write for exactly one cycle, clears pending, then goes to IDLE.
- CPU pixel write during FILL, or during DRAIN's own cycle: captured in a one-entry buffer and sets pending.
  - If pending is already 1, the write is dropped and overflow is set (sticky).
  - The buffered write lands after the fill, so CPU data overrides fill data.
- Ctrl start (wr_data[0]=1) while in FILL or DRAIN: ignored. Ctrl wr_data[1]=1 clears overflow; this is allowed in any state.
- Origin registers
  - Writes to x0/y0 load shadow registers from wr_data[10:0].
  - On frame_start, both shadows are copied to the committed x0/y0.
  - If a shadow write and frame_start occur in the same cycle, the committed value takes the newly written data.
- busy = (state != IDLE). pending and overflow are as described above.

## Timing
- Reset values
  - sprite_we=0, sprite_addr=0, sprite_pixel=0.
  - x0=y0=0; shadows=0.
  - pending=0, overflow=0; fill counter=0.
  - busy=1, because the FSM starts in FILL.
- Post-reset fill
  - sprite_we is high for exactly 2^ADDR consecutive cycles, starting on the first clock edge after reset_n deasserts.
  - Addresses ascend 0..255 (for ADDR=8).
- Latency
  - CPU pixel write to sprite_we: 1 cycle (all outputs are registered).
  - Ctrl start to first fill write: 1 cycle.
  - Last fill write to buffered write: 1 cycle, with no gap.
- rd_data is combinational from the status flops, so zero-latency reads.
- Fill address width is ADDR bits; the counter terminates at all-ones and does not wrap to restart.
- Reset asserted mid-fill or mid-DRAIN: everything clears immediately (async). The buffered write is lost, and a fresh KEY_COLOR fill starts after release.
- frame_start during FILL still commits the origin; origin logic is independent of the FSM.

## Structure
- Shared package `mouse_ctrl_pkg`:
  - state enum (IDLE/FILL/DRAIN)
  - register offsets (REG_X0=0, REG_Y0=1, REG_CTRL=2)
  - the addr[13] region-select bit index
  - ctrl bit positions (START=0, CLR_OVF=1, fill colour LSB=16)
- Single module, no sub-module. A separate top-level wrapper instantiates this block together with the sprite source.

## Test plan
- Reset release → 256 consecutive writes, addr 0..255, pixel 12'h000; busy falls on the cycle after addr 255.
- IDLE, write addr=14'h0012 with data 12'hF0F → one cycle later: sprite_we=1, sprite_addr=8'h12, sprite_pixel=12'hF0F.
- Ctrl write 32'h0ABC_0001 → fill of all addresses with 12'hABC. A mid-fill pixel write (addr 5, 12'h123) → pending=1, and addr 5/12'h123 is written on the cycle after addr 255.
- Two mid-fill pixel writes → second dropped, overflow=1. Ctrl write 32'h2 → overflow=0.
- Write x0=100 and y0=50 with no frame_start → outputs stay 0. frame_start pulse → x0=100, y0=50. x0=200 written in the same cycle as frame_start → x0=200.
- Assert reset_n low at fill address 77 with pending=1 → outputs clear at once, buffered write never issued, fresh fill restarts at 0 after release.
